fp_mul: RTL and testbench
=========================

// Module: fp_mul
// PURPOSE
//   Sequential IEEE-754 binary32 multiplier, c_out = a_s * b_s.
//   - Free-running: continuously samples its operands and recomputes; there is no start/done handshake.
//   - Mantissa product uses a 24x24 shift-add datapath, one partial product per cycle.
//   - Standalone arithmetic leaf; consumers sample c_out a fixed number of cycles after changing the operands.
// PARAMETERS
//   none -- binary32 format fixed; format constants live in fp_mul_pkg.
// PORTS
//   clk       in   1   single clock, all state on rising edge
//   rst       in   1   synchronous, active-high reset
//   a_s       in   32  operand A, binary32 {sign,exp[7:0],frac[22:0]}
//   b_s       in   32  operand B, binary32
//   c_out     out  32  registered product, binary32
//   overflow  out  1   registered; 1 when c_out is an overflow-generated infinity
// BEHAVIOUR
//   - Reset: c_out=32'h0, overflow=0, FSM->LOAD, internal registers cleared.
//   - FSM: LOAD -> MUL -> NORM -> DONE -> LOAD, repeating forever.
//     - LOAD (1 cyc): latch a_s/b_s; sign=a^b; exp_sum=ea+eb-127 (10-bit signed); clear accumulator.
//       Mantissas get an implicit 1 (normal) or are zero (exp==0).
//     - MUL (24 cyc): for i=0..23, if mb[i] add ma<<i into 48-bit accumulator.
//     - NORM (1 cyc): if prod[47], frac=prod[46:24], exp_sum+1; else frac=prod[45:23].
//       Rounding is truncation (toward zero).
//     - DONE (1 cyc): write c_out/overflow together, return to LOAD.
//   - Restart: in MUL/NORM, if a_s/b_s differ from latched copies, abort and go to LOAD. The partial result is discarded.
//   - Latency: new result on c_out <=27 cycles after stable operands; 50 cycles always sufficient.
//   - c_out/overflow hold their previous value while a computation runs; only DONE updates them.
//   - Special cases (resolved at NORM, priority order):
//     1. Either operand NaN (exp=FF, frac!=0), or Inf*0: c_out=32'h7FC00000, overflow=0.
//     2. Either operand Inf: {sign,8'hFF,23'h0}, overflow=0.
//     3. Either operand exp==0 (zero/denormal flushed): {sign,31'h0}.
//     4. Final exp>=255: {sign,8'hFF,23'h0}, overflow=1.
//     5. Final exp<=0: flush to {sign,31'h0}, overflow=0.
//   - Reset asserted mid-computation: immediate return to reset state next edge.
// CONFIGURATION
//   FP_MUL_UNDERFLOW_EN defined:
//     - adds output port 'underflow' (1 bit, reset 0), registered in DONE with c_out.
//     - underflow=1 only for case 5 (nonzero operands, exp<=0).
//   Undefined: no port; case 5 still flushes to signed zero silently.
// STRUCTURE
//   fp_mul_pkg:
//     - EXP_W=8, MAN_W=23, EXP_BIAS=127
//     - QNAN=32'h7FC00000
//     - state enum {LOAD,MUL,NORM,DONE}
//     - classify helpers (is_zero/is_inf/is_nan)
//   Sub-module fp_mul_mant_seq:
//     - 24x24 shift-add mantissa multiplier: start, 5-bit bit counter, 48-bit product, done.
//     - fp_mul keeps sign/exponent/special-case logic and the FSM.
// TESTING (drive operands, wait 50 cycles, check c_out/overflow)
//   - Reset: c_out==0, overflow==0.
//   - 40000000*BF000000 -> BF800000; 40000000*3F000000 -> 3F800000.
//   - BE800000*BE000000 -> 3D000000; BE800000*3E000000 -> BD000000; 00000000*40A00000 -> 00000000.
//   - C1900000*41180000 -> C32B0000; C0933333*40933333 -> C1A947AD (truncation check).
//   - 7F5FFFFE*7F5FFFFF -> 7F800000, overflow=1; next normal op clears overflow.
//   - 80800000*01400001 -> 80000000, overflow=0 (underflow=1 with FP_MUL_UNDERFLOW_EN).
//     7F800000*00000000 -> 7FC00000.
//   - Change operands at cycle 10 of MUL: result equals new product within 27 cycles.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Format constants, FSM state type and operand classification helpers
// shared by the fp_mul multiplier and its mantissa datapath.
package fp_mul_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        LOAD,
        MUL,
        NORM,
        DONE
    } state_t;

    // Zero after flushing: any operand with a zero exponent (zero or denormal).
    function automatic logic is_zero(input logic [EXP_W-1:0] e);
        return e == '0;
    endfunction

    function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (e == '1) && (f == '0);
    endfunction

    function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        return (e == '1) && (f != '0);
    endfunction

endpackage

// File: rtl/fp_mul_mant_seq.sv
// 24x24 shift-add mantissa multiplier, one partial product per cycle.
// start clears the accumulator and restarts the bit counter; done is high
// during the cycle that adds the last partial product. Only the upper
// 25 bits of the 48-bit product leave the block, since the result is truncated.
module fp_mul_mant_seq
    import fp_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+1:0] prod_hi,
    output logic             done
);

    logic [2*MAN_W+1:0] acc;
    logic [4:0]         cnt;
    logic               busy;

    // Accumulate ma<<i for every set bit i of mb, LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (mb[cnt]) begin
                acc <= acc + ({{(MAN_W+1){1'b0}}, ma} << cnt);
            end
            if (cnt == 5'd23) begin
                busy <= 1'b0;
            end
            cnt <= cnt + 5'd1;
        end
    end

    assign done    = busy && (cnt == 5'd23);
    assign prod_hi = acc[2*MAN_W+1:MAN_W];

endmodule

// File: rtl/fp_mul.sv
// Free-running sequential binary32 multiplier: c_out = a_s * b_s, truncated.
// Optional build macro FP_MUL_UNDERFLOW_EN adds an 'underflow' flag output.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   LOAD  | latch operands, sign, biased exponent sum; clear accumulator
//   MUL   | 24 shift-add steps; operand change aborts back to LOAD
//   NORM  | normalise, truncate, resolve special cases into result regs
//   DONE  | publish result and flags on c_out/overflow, then reload
module fp_mul
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_s,
    input  logic [31:0] b_s,
    output logic [31:0] c_out,
    output logic        overflow
`ifdef FP_MUL_UNDERFLOW_EN
    ,
    output logic        underflow
`endif
);

    state_t              state, state_nxt;
    logic [31:0]         a_r, b_r;
    logic                sign_r;
    logic signed [9:0]   exp_sum_r;
    logic [31:0]         res_r, res_nxt;
    logic                ovf_r, ovf_nxt;
    logic [MAN_W:0]      ma, mb;
    logic [MAN_W+1:0]    prod_hi;
    logic                mant_done;
    logic                changed;
    logic signed [9:0]   exp_fin;
    logic [MAN_W-1:0]    frac;
    logic                nan_case, inf_case, zero_case;
`ifdef FP_MUL_UNDERFLOW_EN
    logic                unf_r, unf_nxt;
`endif

    assign ma      = is_zero(a_r[30:23]) ? '0 : {1'b1, a_r[MAN_W-1:0]};
    assign mb      = is_zero(b_r[30:23]) ? '0 : {1'b1, b_r[MAN_W-1:0]};
    assign changed = (a_s != a_r) || (b_s != b_r);

    fp_mul_mant_seq u_mant (
        .clk     (clk),
        .rst     (rst),
        .start   (state == LOAD),
        .ma      (ma),
        .mb      (mb),
        .prod_hi (prod_hi),
        .done    (mant_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state: fixed LOAD/MUL/NORM/DONE loop, aborting when operands move.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = MUL;
            MUL:     if (changed) state_nxt = LOAD;
                     else if (mant_done) state_nxt = NORM;
            NORM:    state_nxt = changed ? LOAD : DONE;
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Normalisation, truncation and special-case priority.
    always_comb begin
        exp_fin   = exp_sum_r + $signed({9'b0, prod_hi[MAN_W+1]});
        frac      = prod_hi[MAN_W+1] ? prod_hi[MAN_W:1] : prod_hi[MAN_W-1:0];
        nan_case  = is_nan(a_r[30:23], a_r[MAN_W-1:0]) || is_nan(b_r[30:23], b_r[MAN_W-1:0])
                 || (is_inf(a_r[30:23], a_r[MAN_W-1:0]) && is_zero(b_r[30:23]))
                 || (is_inf(b_r[30:23], b_r[MAN_W-1:0]) && is_zero(a_r[30:23]));
        inf_case  = is_inf(a_r[30:23], a_r[MAN_W-1:0]) || is_inf(b_r[30:23], b_r[MAN_W-1:0]);
        zero_case = is_zero(a_r[30:23]) || is_zero(b_r[30:23]);
        res_nxt   = {sign_r, exp_fin[EXP_W-1:0], frac};
        ovf_nxt   = 1'b0;
`ifdef FP_MUL_UNDERFLOW_EN
        unf_nxt   = 1'b0;
`endif
        if (nan_case) begin
            res_nxt = QNAN;
        end else if (inf_case) begin
            res_nxt = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_case) begin
            res_nxt = {sign_r, 31'h0};
        end else if (exp_fin >= 10'sd255) begin
            res_nxt = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_nxt = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            res_nxt = {sign_r, 31'h0};
`ifdef FP_MUL_UNDERFLOW_EN
            unf_nxt = 1'b1;
`endif
        end
    end

    // Operand latch in LOAD, result capture in NORM, publish in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            exp_sum_r <= '0;
            res_r     <= '0;
            ovf_r     <= 1'b0;
            c_out     <= '0;
            overflow  <= 1'b0;
`ifdef FP_MUL_UNDERFLOW_EN
            unf_r     <= 1'b0;
            underflow <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    a_r       <= a_s;
                    b_r       <= b_s;
                    sign_r    <= a_s[31] ^ b_s[31];
                    exp_sum_r <= $signed({2'b00, a_s[30:23]} + {2'b00, b_s[30:23]} - 10'(EXP_BIAS));
                end
                NORM: begin
                    res_r <= res_nxt;
                    ovf_r <= ovf_nxt;
`ifdef FP_MUL_UNDERFLOW_EN
                    unf_r <= unf_nxt;
`endif
                end
                DONE: begin
                    c_out    <= res_r;
                    overflow <= ovf_r;
`ifdef FP_MUL_UNDERFLOW_EN
                    underflow <= unf_r;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// Self-checking bench for fp_mul: arithmetic reference model, a steady-state
// compare process, directed literal vectors, restart/reset scenarios and
// randomized operands.
module tb_fp_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_s, b_s;
    logic [31:0] c_out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul dut (
        .clk      (clk),
        .rst      (rst),
        .a_s      (a_s),
        .b_s      (b_s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    // Reference: returns {overflow, c_out} straight from the binary32 rules.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic        nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        logic [47:0] p;
        logic [22:0] fr;
        int          e;
        s     = a[31] ^ b[31];
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        zer_a = (a[30:23] == 8'h00);
        zer_b = (b[30:23] == 8'h00);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a))
            return {1'b0, 32'h7FC00000};
        if (inf_a || inf_b)
            return {1'b0, s, 8'hFF, 23'h0};
        if (zer_a || zer_b)
            return {1'b0, s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            fr = p[46:24];
            e  = e + 1;
        end else begin
            fr = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], fr};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got ovf=%b c=%h, want ovf=%b c=%h",
                     name, act[32], act[31:0], req[32], req[31:0]);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        a_s = a;
        b_s = b;
    endtask

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic o);
        drive(a, b);
        repeat (50) @(negedge clk);
        chk({name, "_model"}, model(a, b), {o, c});
        chk(name, {overflow, c_out}, {o, c});
    endtask

    // Steady-state compare: once operands have been stable for 50 cycles,
    // every cycle's outputs must equal the model.
    initial begin : cmp
        logic [31:0] pa, pb;
        int          settle;
        pa = '0;
        pb = '0;
        settle = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || a_s !== pa || b_s !== pb) settle = 0;
            else                                           settle++;
            pa = a_s;
            pb = b_s;
            if (settle >= 50)
                chk("steady", {overflow, c_out}, model(a_s, b_s));
        end
    end

    function automatic logic [31:0] gen_op();
        logic [31:0] f;
        logic        s;
        int          cat;
        f   = $urandom;
        s   = 1'($urandom_range(0, 1));
        cat = $urandom_range(0, 15);
        case (cat)
            0:       return {s, 8'hFF, f[22:1], 1'b1};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'h00, f[22:0]};
            3:       return {s, 8'($urandom_range(200, 254)), f[22:0]};
            4:       return {s, 8'($urandom_range(1, 60)), f[22:0]};
            default: return {s, 8'($urandom_range(64, 190)), f[22:0]};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        a_s = '0;
        b_s = '0;
        repeat (3) @(negedge clk);
        chk("reset", {overflow, c_out}, 33'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        lit("two_x_mhalf",  32'h40000000, 32'hBF000000, 32'hBF800000, 1'b0);
        lit("two_x_half",   32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0);
        lit("neg_x_neg",    32'hBE800000, 32'hBE000000, 32'h3D000000, 1'b0);
        lit("neg_x_pos",    32'hBE800000, 32'h3E000000, 32'hBD000000, 1'b0);
        lit("zero_x_five",  32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
        lit("m18_x_9p5",    32'hC1900000, 32'h41180000, 32'hC32B0000, 1'b0);
        lit("truncation",   32'hC0933333, 32'h40933333, 32'hC1A947AD, 1'b0);
        lit("overflow",     32'h7F5FFFFE, 32'h7F5FFFFF, 32'h7F800000, 1'b1);
        lit("ovf_cleared",  32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0);
        lit("underflow",    32'h80800000, 32'h01400001, 32'h80000000, 1'b0);
        lit("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
        lit("nan_x_one",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        lit("inf_x_mtwo",   32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0);

        // Restart: reset aligns the FSM so LOAD samples at the first edge
        // after release; operands change during the 11th MUL cycle.
        @(posedge clk);
        #1 rst = 1'b1;
        a_s = 32'h40000000;
        b_s = 32'h40400000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        a_s = 32'hC0400000;
        b_s = 32'h40A00000;
        repeat (20) @(negedge clk);
        chk("restart_hold", {overflow, c_out}, 33'h0);
        repeat (9) @(negedge clk);
        chk("restart_27", {overflow, c_out}, {1'b0, 32'hC1700000});

        // Reset in the middle of a computation, with overflow previously set.
        lit("overflow2", 32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1);
        drive(32'h3F800000, 32'h3F800000);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_mid", {overflow, c_out}, 33'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        lit("after_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);

        // Randomized operands; some vectors are cut short to exercise aborts.
        for (int i = 0; i < 70; i++) begin
            drive(gen_op(), gen_op());
            if ($urandom_range(0, 4) == 0)
                repeat ($urandom_range(1, 40)) @(posedge clk);
            else
                repeat ($urandom_range(52, 56)) @(posedge clk);
        end
        repeat (55) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
